mem_arbiter_sized: RTL and testbench
====================================

// Module: mem_arbiter_sized
// PURPOSE
//  Byte-serial memory controller serving NUM_PORTS requesters (ifetch, LSU, ...) over the 8-bit RAM/IO bus.
//  Supports byte/half/word reads and writes with zero-extended read data.
//  Arbitration is round-robin or fixed priority.
//  Sits between the cache/LSU front-ends and the top-level mem_* pins; one access in flight at a time.
// PARAMETERS
//  NUM_PORTS  2  number of requester ports (>=1)
//  PRIO_MODE  0  0 = round-robin, 1 = fixed priority (highest index wins)
// PORTS
//  clk_in     in   1            system clock
//  rst_in     in   1            asynchronous, active-low reset
//  rdy_in     in   1            global ready; 0 freezes all state
//  mem_din    in   8            read byte from memory (valid cycle after its address)
//  mem_dout   out  8            write byte to memory
//  mem_a      out  32           byte address
//  mem_wr     out  1            1 = write cycle
//  req_valid  in   NUM_PORTS    per-port request, held until that port's req_ready
//  req_wr     in   NUM_PORTS    per-port 1 = write
//  req_size   in   2*NUM_PORTS  per-port size: 0 byte, 1 half, 2 word, 3 treated as word
//  req_addr   in   32*NUM_PORTS per-port start address
//  req_wdata  in   32*NUM_PORTS per-port write data, little-endian, low bytes used
//  req_ready  out  NUM_PORTS    one-cycle done pulse, one-hot
//  resp_data  out  32           read result, valid while req_ready is high
// BEHAVIOUR
//  Reset (rst_in=0, any time incl. mid-access):
//  - Abandons the access; state IDLE.
//  - mem_a=0, mem_dout=0, mem_wr=0, req_ready=0, resp_data=0, RR pointer=0.
//  rdy_in=0: every register holds (incl. mem_wr, mem_a); no request sampled.
//  States: IDLE -> XFER -> DONE -> IDLE.
//  IDLE, some req_valid=1 at edge E0:
//  - Grant one port; latch addr/wdata/wr/size.
//  - S = 1/2/4 bytes.
//  - Drive mem_a=addr, mem_wr=wr (0 for reads), mem_dout=wdata[7:0]; count=0; go XFER.
//  XFER, edges E1..E(S-1):
//  - mem_a += 1 (32-bit wrap 0xFFFFFFFF->0); mem_dout = next wdata byte.
//  - Read: byte i is captured from mem_din at edge E(i+1), into resp_data[8i+7:8i].
//  Edge E_S:
//  - mem_wr=0; req_ready[granted]=1; go DONE.
//  - Read: final byte captured; upper unused bytes are 0 (zero-extend).
//  DONE (one cycle): req_ready and resp_data valid; no arbitration; next edge req_ready=0, go IDLE.
//  - Requester drops or changes req_valid at the edge ending DONE.
//  Latency: S+1 edges from accept to ready; back-to-back accesses issue every S+2 cycles.
//  Arbitration:
//  - PRIO_MODE=1: the highest-index valid port wins.
//  - PRIO_MODE=0: search starts at pointer p; after a grant to port g, p=(g+1) mod NUM_PORTS.
//  Requests changing while not granted are legal; the granted port's inputs are ignored after E0.
//  No alignment check; misaligned half/word access simply spans consecutive bytes.
//  resp_data holds its value after DONE until the next read capture; writes leave it unchanged.
// TESTING
//  1. Read word @0x100, RAM 11 22 33 44 -> ready after 5 edges, resp_data=0x44332211.
//  2. Write half 0xBEEF @0x201 -> mem_wr=1 with (0x201,EF),(0x202,BE); mem_wr=0 at ready.
//  3. Ports 0,1 both valid continuously, PRIO_MODE=0 -> grants 0,1,0,1.
//     PRIO_MODE=1 -> always port 1.
//  4. Read byte @0xFFFFFFFF then word @0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
//     Byte read upper 24 bits = 0.
//  5. rdy_in=0 for 3 cycles mid-word-read -> outputs frozen; result and total latency +3 exactly.
//  6. rst_in low mid-write, released -> no further mem_wr; all outputs 0; next grant goes to port 0.

Source files
------------

// File: rtl/mem_arbiter_sized.sv
// Byte-serial memory controller: arbitrates NUM_PORTS requesters onto an 8-bit RAM/IO bus,
// one byte/half/word access in flight at a time, zero-extended read data.

module mem_arbiter_sized_lane #(
    parameter int LANE = 0
) (
    input  logic       cap_en,
    input  logic [1:0] cnt,
    input  logic [7:0] din,
    input  logic [7:0] cur,
    output logic [7:0] nxt
);
    // First captured byte of a read clears the upper lanes, giving zero extension.
    always_comb begin
        nxt = cur;
        if (cap_en) begin
            if (cnt == 2'(LANE))  nxt = din;
            else if (cnt == 2'd0) nxt = 8'h00;
        end
    end
endmodule

module mem_arbiter_sized #(
    parameter int NUM_PORTS = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic [7:0]                 mem_din,
    output logic [7:0]                 mem_dout,
    output logic [31:0]                mem_a,
    output logic                       mem_wr,
    input  logic [NUM_PORTS-1:0]       req_valid,
    input  logic [NUM_PORTS-1:0]       req_wr,
    input  logic [NUM_PORTS-1:0][1:0]  req_size,
    input  logic [NUM_PORTS-1:0][31:0] req_addr,
    input  logic [NUM_PORTS-1:0][31:0] req_wdata,
    output logic [NUM_PORTS-1:0]       req_ready,
    output logic [31:0]                resp_data
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  last;
        logic [31:0] wdata;
    } xact_t;

    state_t                state_q, state_d;
    xact_t                 xact_q, xact_d;
    logic [PW-1:0]         grant_q, grant_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [31:0]           mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [NUM_PORTS-1:0]  req_ready_q, req_ready_d;
    logic [3:0][7:0]       resp_q, resp_d;

    logic                  gnt_vld;
    logic [PW-1:0]         gnt_idx, gnt_nxt, cand;
    logic                  cap_en;

    // Later loop iterations override earlier ones: ascending gives highest index,
    // descending offsets from the pointer gives the first port at or after it.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (PRIO_MODE != 0) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand = PW'(i);
                if (req_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                cand = PW'((int'(ptr_q) + i) % NUM_PORTS);
                if (req_valid[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        gnt_nxt = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        xact_d      = xact_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        req_ready_d = req_ready_q;
        cap_en      = 1'b0;
        if (rdy_in) begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        xact_d.wr    = req_wr[gnt_idx];
                        xact_d.wdata = req_wdata[gnt_idx];
                        case (req_size[gnt_idx])
                            2'd0:    xact_d.last = 2'd0;
                            2'd1:    xact_d.last = 2'd1;
                            default: xact_d.last = 2'd3;
                        endcase
                        grant_d = gnt_idx;
                        if (PRIO_MODE == 0) ptr_d = gnt_nxt;
                        mem_a_d    = req_addr[gnt_idx];
                        mem_wr_d   = req_wr[gnt_idx];
                        mem_dout_d = req_wdata[gnt_idx][7:0];
                        cnt_d      = 2'd0;
                        state_d    = XFER;
                    end
                end
                XFER: begin
                    cap_en = !xact_q.wr;
                    if (cnt_q == xact_q.last) begin
                        mem_wr_d             = 1'b0;
                        req_ready_d          = '0;
                        req_ready_d[grant_q] = 1'b1;
                        state_d              = DONE;
                    end else begin
                        cnt_d      = cnt_q + 2'd1;
                        mem_a_d    = mem_a_q + 32'd1;
                        mem_dout_d = xact_q.wdata[{cnt_d, 3'b000} +: 8];
                    end
                end
                DONE: begin
                    req_ready_d = '0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_lane
        mem_arbiter_sized_lane #(.LANE(b)) u_lane (
            .cap_en (cap_en),
            .cnt    (cnt_q),
            .din    (mem_din),
            .cur    (resp_q[b]),
            .nxt    (resp_d[b])
        );
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            xact_q      <= '0;
            grant_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            req_ready_q <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            xact_q      <= xact_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            req_ready_q <= req_ready_d;
            resp_q      <= resp_d;
        end
    end

    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign mem_wr    = mem_wr_q;
    assign req_ready = req_ready_q;
    assign resp_data = resp_q;
endmodule

// File: tb/tb_mem_arbiter_sized.sv
// Scoreboard bench for mem_arbiter_sized: round-robin instance fully checked,
// a fixed-priority instance shares the request inputs.
`timescale 1ns/1ps

module tb_mem_arbiter_sized;
    localparam int NP = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    always #5 clk_in = ~clk_in;

    logic [7:0]           mem_din, mem_dout, mem_din2, mem_dout2;
    logic [31:0]          mem_a, mem_a2, resp_data, resp_data2;
    logic                 mem_wr, mem_wr2;
    logic [NP-1:0]        req_valid, req_wr, req_ready, req_ready2;
    logic [NP-1:0][1:0]   req_size;
    logic [NP-1:0][31:0]  req_addr, req_wdata;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h11;
            32'h0000_0101: return 8'h22;
            32'h0000_0102: return 8'h33;
            32'h0000_0103: return 8'h44;
            32'hFFFF_FFFE: return 8'hA1;
            32'hFFFF_FFFF: return 8'hB2;
            32'h0000_0000: return 8'hC3;
            32'h0000_0001: return 8'hD4;
            default:       return a[7:0] ^ a[15:8] ^ 8'h3C;
        endcase
    endfunction

    assign mem_din  = ram_rd(mem_a);
    assign mem_din2 = ram_rd(mem_a2);

    mem_arbiter_sized #(.NUM_PORTS(NP), .PRIO_MODE(0)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_data(resp_data)
    );

    mem_arbiter_sized #(.NUM_PORTS(NP), .PRIO_MODE(1)) u_prio (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din2),
        .mem_dout(mem_dout2), .mem_a(mem_a2), .mem_wr(mem_wr2),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready2), .resp_data(resp_data2)
    );

    typedef struct {int port; logic [31:0] data;} rsp_t;
    typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    int n_cmp = 0, n_err = 0, cyc = 0, n_ready = 0, ready_cyc = 0, n_prio = 0;
    bit prio_phase = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Main monitor: committed write cycles and ready pulses against the queues.
    always @(negedge clk_in) begin : mon
        rsp_t r;
        wr_t  w;
        if (rst_in) begin
            if (rdy_in && mem_wr) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected write: got a=%h d=%h want none", mem_a, mem_dout);
                end else begin
                    w = wr_q.pop_front();
                    check("write addr", mem_a, w.a);
                    check("write data", {24'h0, mem_dout}, {24'h0, w.d});
                end
            end
            if (|req_ready) begin
                n_ready++;
                ready_cyc = cyc;
                check("mem_wr at ready", {31'h0, mem_wr}, 32'h0);
                if (rsp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected ready: got %b want none", req_ready);
                end else begin
                    r = rsp_q.pop_front();
                    check("ready port", {30'h0, req_ready}, 32'h1 << r.port);
                    check("resp_data", resp_data, r.data);
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst_in && prio_phase && |req_ready2) begin
            n_prio++;
            check("prio grant", {30'h0, req_ready2}, 32'h2);
            check("prio resp", resp_data2, 32'h0000_001C);
            check("prio bus idle", {23'h0, mem_wr2, mem_dout2}, 32'h0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_readies(input int tgt);
        int g = 0;
        while (n_ready < tgt && g < 200) begin
            @(posedge clk_in); #1;
            g++;
        end
        if (n_ready < tgt) begin
            n_cmp++; n_err++;
            $display("FAIL ready timeout: got %0d readies want %0d", n_ready, tgt);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " mem_a"},     mem_a, 32'h0);
        check({tag, " mem_dout"},  {24'h0, mem_dout}, 32'h0);
        check({tag, " mem_wr"},    {31'h0, mem_wr}, 32'h0);
        check({tag, " req_ready"}, {30'h0, req_ready}, 32'h0);
        check({tag, " resp_data"}, resp_data, 32'h0);
    endtask

    task automatic run_one(input int p, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input int lat);
        int start, tgt;
        req_wr[p]    = wr;
        req_size[p]  = sz;
        req_addr[p]  = a;
        req_wdata[p] = wd;
        req_valid[p] = 1'b1;
        start = cyc;
        tgt   = n_ready + 1;
        wait_readies(tgt);
        check("latency", ready_cyc - start, lat);
        req_valid[p] = 1'b0;
    endtask

    initial begin
        int start, tgt;
        req_valid = '0; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        @(negedge clk_in);
        chk_zero("reset");
        @(posedge clk_in); #1 rst_in = 1'b1;
        step(2);

        // Both ports valid: round-robin alternates, fixed priority stays on port 1.
        req_addr[0] = 32'h10; req_addr[1] = 32'h20;
        rsp_q.push_back('{0, 32'h0000_002C});
        rsp_q.push_back('{1, 32'h0000_001C});
        rsp_q.push_back('{0, 32'h0000_002C});
        rsp_q.push_back('{1, 32'h0000_001C});
        prio_phase = 1'b1;
        tgt = n_ready + 4;
        req_valid = 2'b11;
        wait_readies(tgt);
        req_valid = '0;
        check("prio count", n_prio, 4);
        prio_phase = 1'b0;
        step(2);

        rsp_q.push_back('{0, 32'h4433_2211});
        run_one(0, 1'b0, 2'd2, 32'h100, 32'h0, 5);
        step(2);

        wr_q.push_back('{32'h201, 8'hEF});
        wr_q.push_back('{32'h202, 8'hBE});
        rsp_q.push_back('{0, 32'h4433_2211});
        run_one(0, 1'b1, 2'd1, 32'h201, 32'h0000_BEEF, 3);
        step(2);

        rsp_q.push_back('{1, 32'h0000_00B2});
        run_one(1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0, 2);
        rsp_q.push_back('{1, 32'hD4C3_B2A1});
        run_one(1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 5);
        step(2);

        // Stall three cycles after the first byte of a word read.
        rsp_q.push_back('{0, 32'h4433_2211});
        req_wr[0] = 1'b0; req_size[0] = 2'd2; req_addr[0] = 32'h100; req_valid[0] = 1'b1;
        start = cyc;
        tgt   = n_ready + 1;
        step(2);
        rdy_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            check("freeze mem_a", mem_a, 32'h101);
            check("freeze mem_wr", {31'h0, mem_wr}, 32'h0);
            check("freeze resp", resp_data, 32'h0000_0011);
            @(posedge clk_in); #1;
        end
        rdy_in = 1'b1;
        wait_readies(tgt);
        check("freeze latency", ready_cyc - start, 8);
        req_valid[0] = 1'b0;
        step(2);

        // Reset in the middle of a word write; only the first byte commits.
        wr_q.push_back('{32'h300, 8'h0D});
        req_wr[0] = 1'b1; req_size[0] = 2'd2; req_addr[0] = 32'h300;
        req_wdata[0] = 32'hCAFE_F00D; req_valid[0] = 1'b1;
        step(2);
        rst_in = 1'b0;
        req_valid = '0;
        @(negedge clk_in);
        chk_zero("mid reset");
        step(2);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk_zero("post reset");
        @(posedge clk_in); #1;

        req_wr = '0; req_size = '0; req_addr[0] = 32'h10; req_addr[1] = 32'h20;
        rsp_q.push_back('{0, 32'h0000_002C});
        prio_phase = 1'b1;
        start = cyc;
        tgt   = n_ready + 1;
        req_valid = 2'b11;
        wait_readies(tgt);
        req_valid = '0;
        check("post reset latency", ready_cyc - start, 2);
        check("post reset prio count", n_prio, 5);
        prio_phase = 1'b0;
        step(3);

        check("rsp queue drained", rsp_q.size(), 0);
        check("wr queue drained", wr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
